// File: rtl/alu_seq.sv
// Registered EX-stage ALU with XLEN-wide datapath, RV64 word ops and an
// iterative shifter that moves up to SHIFT_STEP bits per cycle.
//
// Handshake: an op transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. While
// out_valid is high and out_ready low, result/cmp_* and state hold. in_ready
// never depends on in_valid, and out_valid never depends on out_ready.
module alu_seq #(
    parameter int XLEN       = 64,
    parameter int SHIFT_STEP = 8,
    localparam int SW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic            unsign,
    input  logic            word,
    input  logic [XLEN-1:0] ds1,
    input  logic [XLEN-1:0] ds2,
    input  logic [SW-1:0]   shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cmp_lt,
    output logic            cmp_eq,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MAX  = 4'd10;
    localparam logic [3:0] OP_MIN  = 4'd11;
    localparam logic [3:0] OP_ANDN = 4'd12;

    // Shift direction kept while iterating
    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] acc;
    logic [SW-1:0]   rem;
    logic [1:0]      sh_kind;
    logic            sh_word;

    logic            word_eff;
    logic            lt;
    logic            eq;
    logic            is_shift;
    logic [SW-1:0]   shamt_eff;
    logic [XLEN-1:0] shift_src;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] alu_res;
    logic [SW:0]     rem_w;
    logic [SW:0]     step_w;
    logic [SW:0]     k;
    logic [XLEN-1:0] acc_step;
    logic [SW-1:0]   rem_next;
    logic            accept;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return XLEN'($signed(x[31:0]));
    endfunction

    // Word mode only exists on a 64-bit datapath
    assign word_eff = word & (XLEN == 64);

    assign in_ready  = ~flush & ((state == S_IDLE) | ((state == S_HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Operand decode and single-cycle result for everything except a nonzero shift
    always_comb begin
        lt        = unsign ? (ds1 < ds2) : ($signed(ds1) < $signed(ds2));
        eq        = (ds1 == ds2);
        is_shift  = (op == OP_SLL) | (op == OP_SRL) | (op == OP_SRA);
        shamt_eff = word_eff ? (shamt & SW'(31)) : shamt;
        shift_src = ds1;
        if (word_eff && op == OP_SRL) shift_src = XLEN'(ds1[31:0]);
        if (word_eff && op == OP_SRA) shift_src = sext32(ds1);
        sum  = ds1 + ds2;
        diff = ds1 - ds2;
        case (op)
            OP_PASS: alu_res = ds1;
            OP_ADD:  alu_res = word_eff ? sext32(sum) : sum;
            OP_SUB:  alu_res = word_eff ? sext32(diff) : diff;
            OP_AND:  alu_res = ds1 & ds2;
            OP_OR:   alu_res = ds1 | ds2;
            OP_XOR:  alu_res = ds1 ^ ds2;
            OP_SLT:  alu_res = XLEN'(lt);
            OP_SLL, OP_SRL, OP_SRA:
                     alu_res = word_eff ? sext32(shift_src) : shift_src;
            OP_MAX:  alu_res = lt ? ds2 : ds1;
            OP_MIN:  alu_res = (lt | eq) ? ds1 : ds2;
            OP_ANDN: alu_res = ds1 & ~ds2;
            default: alu_res = '0;
        endcase
    end

    // One iteration of the shifter: move by min(rem, SHIFT_STEP)
    always_comb begin
        rem_w    = {1'b0, rem};
        step_w   = (SW + 1)'(SHIFT_STEP);
        k        = (rem_w < step_w) ? rem_w : step_w;
        rem_next = rem - k[SW-1:0];
        case (sh_kind)
            K_SLL:   acc_step = acc << k;
            K_SRL:   acc_step = acc >> k;
            default: acc_step = $signed(acc) >>> k;
        endcase
    end

    // Control FSM plus result/compare registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            result  <= '0;
            cmp_lt  <= 1'b0;
            cmp_eq  <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            sh_kind <= K_SLL;
            sh_word <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            cmp_lt <= lt;
            cmp_eq <= eq;
            if (is_shift && shamt_eff != '0) begin
                acc     <= shift_src;
                rem     <= shamt_eff;
                sh_word <= word_eff;
                sh_kind <= (op == OP_SLL) ? K_SLL : (op == OP_SRL) ? K_SRL : K_SRA;
                state   <= S_SHIFT;
            end else begin
                result <= alu_res;
                state  <= S_HOLD;
            end
        end else if (state == S_SHIFT) begin
            acc <= acc_step;
            rem <= rem_next;
            if (rem_next == '0) begin
                result <= sh_word ? sext32(acc_step) : acc_step;
                state  <= S_HOLD;
            end
        end else if (state == S_HOLD && out_ready) begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (XLEN=64, SHIFT_STEP=8) with a result scoreboard.
module tb_alu_seq;
    localparam int XLEN = 64;
    localparam int STEP = 8;
    localparam int W    = XLEN + 2;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic            unsign;
    logic            word;
    logic [XLEN-1:0] ds1;
    logic [XLEN-1:0] ds2;
    logic [5:0]      shamt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            cmp_lt;
    logic            cmp_eq;
    logic            busy;
    logic [1:0]      state_dbg;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int n_pops   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .unsign(unsign), .word(word),
        .ds1(ds1), .ds2(ds2), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cmp_lt(cmp_lt),
        .cmp_eq(cmp_eq), .busy(busy), .state_dbg(state_dbg)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    // reference model: {cmp_lt, cmp_eq, result}
    function automatic logic [W-1:0] model(input logic [3:0] o, input logic [63:0] a,
                                           input logic [63:0] b, input logic [5:0] sh,
                                           input logic w, input logic u);
        logic [63:0] r;
        logic [63:0] v;
        logic [63:0] msb;
        logic        l;
        logic        e;
        int          n;
        msb = 64'h8000_0000_0000_0000;
        e = (a == b);
        l = u ? (a < b) : ((a ^ msb) < (b ^ msb));
        n = w ? int'(sh[4:0]) : int'(sh);
        r = '0;
        case (o)
            4'd0:  r = a;
            4'd1:  r = w ? sx(a + b) : a + b;
            4'd2:  r = w ? sx(a - b) : a - b;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = {63'd0, l};
            4'd7: begin
                v = a;
                for (int i = 0; i < n; i++) v = {v[62:0], 1'b0};
                r = w ? sx(v) : v;
            end
            4'd8: begin
                v = w ? {32'd0, a[31:0]} : a;
                for (int i = 0; i < n; i++) v = {1'b0, v[63:1]};
                r = w ? sx(v) : v;
            end
            4'd9: begin
                v = w ? sx(a) : a;
                for (int i = 0; i < n; i++) v = {v[63], v[63:1]};
                r = w ? sx(v) : v;
            end
            4'd10: r = l ? b : a;
            4'd11: r = (l || e) ? a : b;
            4'd12: r = a & ~b;
            default: r = '0;
        endcase
        return {l, e, r};
    endfunction

    // scoreboard: compare every transferred result against the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_output observed=%0h expected=none", result);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("scoreboard", {cmp_lt, cmp_eq, result}, e);
                n_pops++;
            end
        end
    end

    // driver: called #1 after a rising edge, returns #1 after the accept edge
    task automatic send(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] sh, input logic w, input logic u);
        bit done;
        done = 0;
        op = o; ds1 = a; ds2 = b; shamt = sh; word = w; unsign = u;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(o, a, b, sh, w, u));
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=no_accept expected=accept");
        end
    endtask

    // wait for out_valid, report latency and outputs seen, re-align after the edge
    task automatic wait_valid(output int lat, output logic [63:0] r, output logic l,
                              output logic e, input bit check_busy);
        bit seen;
        seen = 0;
        lat = -1; r = '0; l = 1'b0; e = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (check_busy) chk("busy_during_op", busy, 1'b1);
            if (out_valid) begin
                seen = 1;
                lat = cyc - acc_cyc;
                r = result; l = cmp_lt; e = cmp_eq;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $error("FAIL valid_timeout observed=no_valid expected=valid");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          start;
        int          p0;
        logic [63:0] r;
        logic        l;
        logic        e;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; unsign = 1'b0;
        word = 1'b0; ds1 = '0; ds2 = '0; shamt = '0; out_ready = 1'b1;

        // reset state
        #23;
        chk("rst_result", result, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cmp_lt", cmp_lt, 0);
        chk("rst_cmp_eq", cmp_eq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // 1: word ADD overflow sign-extends
        send(4'd1, 64'h7FFF_FFFF, 64'd1, 6'd0, 1'b1, 1'b0);
        wait_valid(lat, r, l, e, 1'b0);
        chk("t1_latency", lat, 1);
        chk("t1_result", r, 64'hFFFF_FFFF_8000_0000);

        // 2: SRA by 20 in three steps
        send(4'd9, 64'h8000_0000_0000_0000, 64'd0, 6'd20, 1'b0, 1'b0);
        wait_valid(lat, r, l, e, 1'b1);
        chk("t2_latency", lat, 4);
        chk("t2_result", r, 64'hFFFF_F800_0000_0000);

        // 3: SLT signed vs unsigned
        send(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0, 1'b0);
        wait_valid(lat, r, l, e, 1'b0);
        chk("t3s_result", r, 1);
        chk("t3s_cmp_lt", l, 1);
        chk("t3s_cmp_eq", e, 0);
        send(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0, 1'b1);
        wait_valid(lat, r, l, e, 1'b0);
        chk("t3u_result", r, 0);
        chk("t3u_cmp_lt", l, 0);
        chk("t3u_cmp_eq", e, 0);

        // 4: ten back-to-back ADDs at one per cycle
        start = cyc;
        p0 = n_pops;
        for (int i = 0; i < 10; i++)
            send(4'd1, {$urandom, $urandom}, {$urandom, $urandom}, 6'd0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("t4_pops", n_pops - p0, 10);
        chk("t4_cycles", cyc - start, 10);
        @(posedge clk); #1;

        // 4b: consumer stalls for 5 cycles with a new op waiting
        out_ready = 1'b0;
        send(4'd1, 64'd100, 64'd23, 6'd0, 1'b0, 1'b0);
        op = 4'd2; ds1 = 64'd50; ds2 = 64'd8; shamt = '0; word = 1'b0; unsign = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_result", result, 64'd123);
            chk("t4_hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd2, 64'd50, 64'd8, 6'd0, 1'b0, 1'b0);
        wait_valid(lat, r, l, e, 1'b0);
        chk("t4_next_latency", lat, 1);
        chk("t4_next_result", r, 64'd42);

        // 5: flush abandons a long shift
        send(4'd7, 64'd1, 64'd0, 6'd63, 1'b0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_flush", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_out_valid", out_valid, 0);
            chk("t5_busy", busy, 0);
        end
        @(posedge clk); #1;
        send(4'd1, 64'd2, 64'd3, 6'd0, 1'b0, 1'b0);
        wait_valid(lat, r, l, e, 1'b0);
        chk("t5_add_latency", lat, 1);
        chk("t5_add_result", r, 64'd5);

        // 6: asynchronous reset in the middle of a shift
        send(4'd8, {$urandom, $urandom}, 64'd0, 6'd40, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_result", result, 0);
        chk("t6_cmp_lt", cmp_lt, 0);
        chk("t6_cmp_eq", cmp_eq, 0);
        chk("t6_busy", busy, 0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid_after", out_valid, 0);

        // random mix of all opcodes
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            send(4'($urandom_range(0, 15)), a, b, 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(negedge clk); #1;
        end
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
